// File: rtl/inv_add_round_key_seq_if.sv
// Handshake and key bus bundle for the decryption AddRoundKey sequencer.
// The err signal exists only when INV_ARK_ERR_EN is defined.
interface inv_add_round_key_seq_if #(
    parameter int NR_MAX = 14
);
    localparam int W_BITS = 32 * 4 * (NR_MAX + 1);

    logic [1:0]        key_len;
    logic [W_BITS-1:0] w;
    logic              in_valid;
    logic              in_ready;
    logic              in_first;
    logic [127:0]      in_state;
    logic              out_valid;
    logic              out_ready;
    logic [127:0]      out_state;
    logic [3:0]        out_round;
    logic              out_last;
`ifdef INV_ARK_ERR_EN
    logic              err;
`endif

    modport master (
        output key_len, w, in_valid, in_first, in_state, out_ready,
        input  in_ready, out_valid, out_state, out_round, out_last
`ifdef INV_ARK_ERR_EN
        , input err
`endif
    );

    modport slave (
        input  key_len, w, in_valid, in_first, in_state, out_ready,
        output in_ready, out_valid, out_state, out_round, out_last
`ifdef INV_ARK_ERR_EN
        , output err
`endif
    );
endinterface

// File: rtl/inv_add_round_key_seq.sv
// Decryption-side AddRoundKey: walks round keys from Nr down to 0 behind a
// one-deep valid/ready output register. Optional protocol checking: INV_ARK_ERR_EN.
module inv_add_round_key_seq (
    input  logic                      clk,
    input  logic                      reset,
    inv_add_round_key_seq_if.slave    bus
);
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [3:0]   r_rnd;
    logic [3:0]   w_rnd_next;
    logic [3:0]   w_nr;
    logic [3:0]   w_key_rnd;
    logic         w_load;
    logic         w_in_ready;
    logic         w_accept;
    logic [127:0] w_keyed;

    logic         r_out_valid;
    logic [127:0] r_out_state;
    logic [3:0]   r_out_round;
    logic         r_out_last;

`ifdef INV_ARK_ERR_EN
    logic         w_err_set;
    logic         r_err;
`endif

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            2'd0:    nr_of = 4'd10;
            2'd1:    nr_of = 4'd12;
            default: nr_of = 4'd14;
        endcase
    endfunction

    assign w_nr       = nr_of(bus.key_len);
    assign w_in_ready = !r_out_valid | bus.out_ready;
    assign w_accept   = bus.in_valid & w_in_ready;

    // Column c takes word 4r+3-c; byte k of the column lines up with byte k of the word.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            logic [5:0] w_word_idx;
            assign w_word_idx = {w_key_rnd, 2'b00} + 6'(3 - gi);
            assign w_keyed[32*gi +: 32] = bus.in_state[32*gi +: 32]
                                        ^ bus.w[{w_word_idx, 5'b00000} +: 32];
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_rnd_next   = r_rnd;
        w_key_rnd    = r_rnd;
        w_load       = 1'b0;
`ifdef INV_ARK_ERR_EN
        w_err_set    = 1'b0;
`endif
        if (w_accept) begin
            if (bus.in_first) begin
                w_key_rnd    = w_nr;
                w_load       = 1'b1;
                w_rnd_next   = w_nr - 4'd1;
                w_state_next = S_RUN;
`ifdef INV_ARK_ERR_EN
                if (r_state == S_RUN) begin
                    w_err_set = 1'b1;
                end
`endif
            end else if (r_state == S_IDLE) begin
`ifdef INV_ARK_ERR_EN
                w_err_set    = 1'b1;
`else
                w_key_rnd    = w_nr;
                w_load       = 1'b1;
                w_rnd_next   = w_nr - 4'd1;
                w_state_next = S_RUN;
`endif
            end else begin
                w_load = 1'b1;
                // Round 0 closes the block, so rnd never decrements below zero.
                if (r_rnd == 4'd0) begin
                    w_state_next = S_IDLE;
                    w_rnd_next   = 4'd0;
                end else begin
                    w_rnd_next   = r_rnd - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_rnd   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_rnd   <= w_rnd_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_state <= 128'd0;
            r_out_round <= 4'd0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_state <= w_keyed;
            r_out_round <= w_key_rnd;
            r_out_last  <= (w_key_rnd == 4'd0);
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef INV_ARK_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_state = r_out_state;
    assign bus.out_round = r_out_round;
    assign bus.out_last  = r_out_last;
endmodule
